// File: rtl/subtrator_completo_nbits_pkg.sv
// Shared constants and the 1-bit full-subtractor equation used by the
// ripple-borrow subtractor.
package subtrator_completo_nbits_pkg;

  localparam int SUB_DEFAULT_WIDTH = 8;

  // Returns {borrow_out, diff} for one bit position.
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic bin);
    logic d, bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

endpackage

// File: rtl/subtrator_completo_cell.sv
// 1-bit combinational full subtractor: d = a - b - bin, with borrow out.
module subtrator_completo_cell
  import subtrator_completo_nbits_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic [1:0] res;

  assign res    = fs_bit(a_i, b_i, bin_i);
  assign d_o    = res[0];
  assign bout_o = res[1];

endmodule

// File: rtl/subtrator_completo_nbits.sv
// Registered WIDTH-bit ripple-borrow subtractor with overflow/zero flags and
// a sticky self-check against a behavioural subtraction.
module subtrator_completo_nbits
  import subtrator_completo_nbits_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIn,
  output logic             out_valid,
  output logic [WIDTH-1:0] D,
  output logic             BorrowOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Mismatch
);

  logic [WIDTH:0]   bchain;
  logic [WIDTH-1:0] dchain;
  logic [WIDTH:0]   ref_full;

  assign bchain[0] = BorrowIn;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      subtrator_completo_cell u_cell (
        .a_i    (A[gi]),
        .b_i    (B[gi]),
        .bin_i  (bchain[gi]),
        .d_o    (dchain[gi]),
        .bout_o (bchain[gi+1])
      );
    end
  endgenerate

  // Independent reference; any disagreement with the cell chain latches Mismatch.
  assign ref_full = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, BorrowIn};

  logic             vld_q,  vld_d;
  logic [WIDTH-1:0] d_q,    d_d;
  logic             bout_q, bout_d;
  logic             ovf_q,  ovf_d;
  logic             zero_q, zero_d;
  logic             mism_q, mism_d;

  always_comb begin
    vld_d  = in_valid;
    d_d    = d_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    mism_d = mism_q;
    if (in_valid) begin
      d_d    = dchain;
      bout_d = bchain[WIDTH];
      ovf_d  = (A[WIDTH-1] ^ B[WIDTH-1]) & (dchain[WIDTH-1] ^ A[WIDTH-1]);
      zero_d = ~|dchain;
      if ({bchain[WIDTH], dchain} != ref_full) mism_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      mism_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      d_q    <= d_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      mism_q <= mism_d;
    end
  end

  assign out_valid = vld_q;
  assign D         = d_q;
  assign BorrowOut = bout_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;
  assign Mismatch  = mism_q;

endmodule

// File: tb/tb_subtrator_completo_nbits.sv
// Directed and random checks of the registered ripple-borrow subtractor
// at WIDTH=1 and WIDTH=8.
module tb_subtrator_completo_nbits;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int nchk = 0;

  // WIDTH=1 instance
  logic v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bi1 = 1'b0;
  logic ov1, d1, bo1, of1, z1, m1;
  subtrator_completo_nbits #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .BorrowIn(bi1),
    .out_valid(ov1), .D(d1), .BorrowOut(bo1), .Overflow(of1), .Zero(z1), .Mismatch(m1)
  );

  // WIDTH=8 instance
  logic       v8 = 1'b0, bi8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8, bo8, of8, z8, m8;
  logic [7:0] d8;
  subtrator_completo_nbits #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .BorrowIn(bi8),
    .out_valid(ov8), .D(d8), .BorrowOut(bo8), .Overflow(of8), .Zero(z8), .Mismatch(m8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] d, input logic bo,
                      input logic z, input logic of);
    chk({tag, ".valid"}, 32'(ov8), 32'd1);
    chk({tag, ".D"},     32'(d8),  32'(d));
    chk({tag, ".Bout"},  32'(bo8), 32'(bo));
    chk({tag, ".Zero"},  32'(z8),  32'(z));
    chk({tag, ".Ovf"},   32'(of8), 32'(of));
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    a8 = a; b8 = b; bi8 = bin; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
  endtask

  // {A,B,Bin} stimulus and {D,Bout} expectations for the 1-bit cell
  logic [2:0] tab_in  [8] = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b001, 3'b101, 3'b111, 3'b011};
  logic [1:0] tab_exp [8] = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01};

  initial begin
    logic [7:0] ra, rb, ed;
    logic       rbi, eb, ez, eo, pend;
    logic [8:0] full;

    // reset state
    #1 rst = 1'b1;
    #1;
    chk("rst.valid8", 32'(ov8), 32'd0);
    chk("rst.D8",     32'(d8),  32'd0);
    chk("rst.Bout8",  32'(bo8), 32'd0);
    chk("rst.Ovf8",   32'(of8), 32'd0);
    chk("rst.Zero8",  32'(z8),  32'd0);
    chk("rst.Mism8",  32'(m8),  32'd0);
    chk("rst.valid1", 32'(ov1), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a1, b1, bi1} = tab_in[i]; v1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      chk($sformatf("w1[%0d].valid", i), 32'(ov1), 32'd1);
      chk($sformatf("w1[%0d].D", i),     32'(d1),  32'(tab_exp[i][1]));
      chk($sformatf("w1[%0d].Bout", i),  32'(bo1), 32'(tab_exp[i][0]));
    end

    // WIDTH=8 directed
    drive8(8'h05, 8'h03, 1'b0); chk8("sub05_03",  8'h02, 1'b0, 1'b0, 1'b0);
    drive8(8'h03, 8'h05, 1'b1); chk8("sub03_05b", 8'hFD, 1'b1, 1'b0, 1'b0);
    drive8(8'h00, 8'h00, 1'b1); chk8("ripple00",  8'hFF, 1'b1, 1'b0, 1'b0);
    drive8(8'h80, 8'h01, 1'b0); chk8("ovf80_01",  8'h7F, 1'b0, 1'b0, 1'b1);
    drive8(8'h5A, 8'h59, 1'b1); chk8("zero5A",    8'h00, 1'b0, 1'b1, 1'b0);
    drive8(8'h00, 8'h01, 1'b0); chk8("wrap0_1",   8'hFF, 1'b1, 1'b0, 1'b0);
    drive8(8'hFF, 8'hFF, 1'b1); chk8("wrapFF",    8'hFF, 1'b1, 1'b0, 1'b0);

    // in_valid low: outputs hold, out_valid drops
    a8 = 8'h10; b8 = 8'h01; bi8 = 1'b0;
    @(negedge clk);
    chk("hold.valid", 32'(ov8), 32'd0);
    chk("hold.D",     32'(d8),  32'hFF);
    chk("hold.Bout",  32'(bo8), 32'd1);

    // mid-stream asynchronous reset
    a8 = 8'h20; b8 = 8'h01; bi8 = 1'b0; v8 = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_rst.D", 32'(d8), 32'h1F);
    rst = 1'b1;
    #1;
    chk("arst.valid", 32'(ov8), 32'd0);
    chk("arst.D",     32'(d8),  32'd0);
    chk("arst.Bout",  32'(bo8), 32'd0);
    chk("arst.Ovf",   32'(of8), 32'd0);
    @(negedge clk);
    v8 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.valid", 32'(ov8), 32'd0);
    chk("post_rst.D",     32'(d8),  32'd0);

    // random vectors at full throughput, checked one cycle later
    pend = 1'b0; ed = '0; eb = 1'b0; ez = 1'b0; eo = 1'b0;
    for (int i = 0; i <= 10000; i++) begin
      @(negedge clk);
      if (pend) begin
        chk("rnd.valid", 32'(ov8), 32'd1);
        chk("rnd.D",     32'(d8),  32'(ed));
        chk("rnd.Bout",  32'(bo8), 32'(eb));
        chk("rnd.Zero",  32'(z8),  32'(ez));
        chk("rnd.Ovf",   32'(of8), 32'(eo));
      end
      if (i < 10000) begin
        ra  = 8'($urandom_range(0, 255));
        rb  = 8'($urandom_range(0, 255));
        rbi = 1'($urandom_range(0, 1));
        a8 = ra; b8 = rb; bi8 = rbi; v8 = 1'b1;
        full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
        ed = full[7:0];
        eb = full[8];
        ez = (full[7:0] == 8'd0);
        eo = (ra[7] ^ rb[7]) & (full[7] ^ ra[7]);
        pend = 1'b1;
      end else begin
        v8 = 1'b0;
      end
    end
    chk("mism8", 32'(m8), 32'd0);
    chk("mism1", 32'(m1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
